// File: rtl/arith_uitofp_pipe.sv
// Unsigned integer to IEEE-754 binary32/binary64 converter.
// Three-stage valid/ready pipeline: capture, normalise, round-to-nearest-even and pack.
module arith_uitofp_pipe #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [IN_WIDTH-1:0]  a_data,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [OUT_WIDTH-1:0] result_data
);

    localparam int M    = (OUT_WIDTH == 64) ? 52 : 23;
    localparam int EW   = (OUT_WIDTH == 64) ? 11 : 8;
    localparam int BIAS = (OUT_WIDTH == 64) ? 1023 : 127;
    localparam int TW   = IN_WIDTH - 1;
    localparam int XW   = TW + M + 2;

    if (OUT_WIDTH != 32 && OUT_WIDTH != 64) begin : g_bad_out
        $fatal(1, "arith_uitofp_pipe: OUT_WIDTH must be 32 or 64");
    end
    if (IN_WIDTH < 8 || IN_WIDTH > 64) begin : g_bad_in
        $fatal(1, "arith_uitofp_pipe: IN_WIDTH must be 8..64");
    end

    logic                 v1_q;
    logic [IN_WIDTH-1:0]  d1_q;
    logic                 z1_q;

    logic                 v2_q;
    logic [TW-1:0]        t2_q;
    logic [6:0]           e2_q;
    logic                 z2_q;

    logic                 v3_q;
    logic [OUT_WIDTH-1:0] r3_q;

    logic                 ld1;
    logic                 ld2;
    logic                 ld3;

    // A stage may load when it is empty or its content moves on this edge.
    assign ld3 = !v3_q || result_ready;
    assign ld2 = !v2_q || ld3;
    assign ld1 = !v1_q || ld2;

    assign a_ready      = !rst && ld1;
    assign result_valid = v3_q;
    assign result_data  = r3_q;

    logic [6:0]    lz;
    logic [TW-1:0] t2_d;
    logic [6:0]    e2_d;

    always_comb begin
        lz = 7'(IN_WIDTH);
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (d1_q[i]) begin
                lz = 7'(IN_WIDTH - 1 - i);
            end
        end
    end

    // The leading one itself is implicit, so only the bits below it are kept.
    assign t2_d = d1_q[TW-1:0] << lz;
    assign e2_d = 7'(IN_WIDTH - 1) - lz;

    logic [XW-1:0]        ext;
    logic [M-1:0]         frac;
    logic                 guard;
    logic                 sticky;
    logic                 rnd;
    logic                 carry;
    logic [M-1:0]         frac_r;
    logic [EW-1:0]        exp_r;
    logic [OUT_WIDTH-1:0] r3_d;

    assign ext    = {t2_q, {(M + 2){1'b0}}};
    assign frac   = ext[XW-1 -: M];
    assign guard  = ext[XW-1-M];
    assign sticky = |ext[XW-M-2:0];
    assign rnd    = guard && (sticky || frac[0]);

    always_comb begin
        {carry, frac_r} = {1'b0, frac} + {{M{1'b0}}, rnd};
        exp_r = EW'(e2_q) + EW'(BIAS) + EW'(carry);
        r3_d  = z2_q ? '0 : {1'b0, exp_r, frac_r};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            z1_q <= 1'b0;
            v2_q <= 1'b0;
            t2_q <= '0;
            e2_q <= '0;
            z2_q <= 1'b0;
            v3_q <= 1'b0;
            r3_q <= '0;
        end else begin
            if (ld1) begin
                v1_q <= a_valid;
                if (a_valid) begin
                    d1_q <= a_data;
                    z1_q <= (a_data == '0);
                end
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    t2_q <= t2_d;
                    e2_q <= e2_d;
                    z2_q <= z1_q;
                end
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    r3_q <= r3_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_arith_uitofp_pipe.sv
// Bench for arith_uitofp_pipe: three format instances, directed values,
// backpressure, reset mid-stream and randomized streams against a reference model.
module tb_arith_uitofp_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic        av0, ar0, rv0, rr0;
    logic [31:0] ad0, rd0;
    logic        av1, ar1, rv1, rr1;
    logic [31:0] ad1;
    logic [63:0] rd1;
    logic        av2, ar2, rv2, rr2;
    logic [63:0] ad2;
    logic [31:0] rd2;

    always #5 clk = ~clk;

    arith_uitofp_pipe #(.IN_WIDTH(32), .OUT_WIDTH(32)) u0 (
        .clk(clk), .rst(rst),
        .a_valid(av0), .a_ready(ar0), .a_data(ad0),
        .result_valid(rv0), .result_ready(rr0), .result_data(rd0)
    );

    arith_uitofp_pipe #(.IN_WIDTH(32), .OUT_WIDTH(64)) u1 (
        .clk(clk), .rst(rst),
        .a_valid(av1), .a_ready(ar1), .a_data(ad1),
        .result_valid(rv1), .result_ready(rr1), .result_data(rd1)
    );

    arith_uitofp_pipe #(.IN_WIDTH(64), .OUT_WIDTH(32)) u2 (
        .clk(clk), .rst(rst),
        .a_valid(av2), .a_ready(ar2), .a_data(ad2),
        .result_valid(rv2), .result_ready(rr2), .result_data(rd2)
    );

    // Reference: exact integer quotient/remainder rounding, ties to even.
    function automatic logic [63:0] ref_cvt(input logic [63:0] x, input int ow);
        int m;
        int b;
        int p;
        int sh;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        m = (ow == 64) ? 52 : 23;
        b = (ow == 64) ? 1023 : 127;
        if (x == 64'd0) return 64'd0;
        p = 63;
        while (!x[p]) p--;
        if (p <= m) begin
            q = x << (m - p);
        end else begin
            sh   = p - m;
            q    = x >> sh;
            rem  = x - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << (m + 1))) begin
                q = q >> 1;
                p++;
            end
        end
        if (ow == 64) return {1'b0, 11'(p + b), q[51:0]};
        return {32'd0, 1'b0, 8'(p + b), q[22:0]};
    endfunction

    task automatic run_one(input int sel, input logic [63:0] x,
                           output logic [63:0] y, output int lat);
        int cnt;
        bit got;
        cnt = 0;
        got = 1'b0;
        @(negedge clk);
        case (sel)
            0: begin av0 = 1'b1; ad0 = x[31:0]; rr0 = 1'b1; end
            1: begin av1 = 1'b1; ad1 = x[31:0]; rr1 = 1'b1; end
            default: begin av2 = 1'b1; ad2 = x; rr2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        av0 = 1'b0;
        av1 = 1'b0;
        av2 = 1'b0;
        y = '0;
        while (!got && cnt < 12) begin
            @(negedge clk);
            case (sel)
                0: if (rv0) begin got = 1'b1; y = {32'd0, rd0}; end
                1: if (rv1) begin got = 1'b1; y = rd1; end
                default: if (rv2) begin got = 1'b1; y = {32'd0, rd2}; end
            endcase
            if (!got) cnt++;
        end
        lat = got ? cnt + 1 : 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ar0 !== 1'b0 || ar1 !== 1'b0 || ar2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_a_ready got=%b%b%b exp=000", ar0, ar1, ar2);
        end
        checks++;
        if (rv0 !== 1'b0 || rv1 !== 1'b0 || rv2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b%b%b exp=000", rv0, rv1, rv2);
        end
        checks++;
        if (rd0 !== 32'd0 || rd1 !== 64'd0 || rd2 !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got=%h %h %h exp=0", rd0, rd1, rd2);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ar0 !== 1'b1 || ar1 !== 1'b1 || ar2 !== 1'b1) begin
            failures++;
            $display("FAIL release_a_ready got=%b%b%b exp=111", ar0, ar1, ar2);
        end
    endtask

    task automatic test_directed_32();
        logic [31:0] xs [7];
        logic [31:0] es [7];
        logic [63:0] y;
        int lat;
        xs = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h00FFFFFF,
               32'h01000001, 32'h01000003, 32'h01000005};
        es = '{32'h0, 32'h3F800000, 32'h4F800000, 32'h4B7FFFFF,
               32'h4B800000, 32'h4B800002, 32'h4B800002};
        for (int i = 0; i < 7; i++) begin
            run_one(0, {32'd0, xs[i]}, y, lat);
            checks++;
            if (y[31:0] !== es[i]) begin
                failures++;
                $display("FAIL dir32[%0d] in=%h got=%h exp=%h", i, xs[i], y[31:0], es[i]);
            end
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL latency32[%0d] got=%0d exp=3", i, lat);
            end
        end
    endtask

    task automatic test_out64();
        logic [31:0] xs [2];
        logic [63:0] es [2];
        logic [63:0] y;
        int lat;
        xs = '{32'hFFFFFFFF, 32'h80000000};
        es = '{64'h41EFFFFFFFE00000, 64'h41E0000000000000};
        for (int i = 0; i < 2; i++) begin
            run_one(1, {32'd0, xs[i]}, y, lat);
            checks++;
            if (y !== es[i] || lat !== 3) begin
                failures++;
                $display("FAIL out64[%0d] got=%h lat=%0d exp=%h lat=3", i, y, lat, es[i]);
            end
        end
    endtask

    task automatic test_in64();
        logic [63:0] xs [2];
        logic [31:0] es [2];
        logic [63:0] y;
        int lat;
        xs = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000100000001};
        es = '{32'h5F800000, 32'h4F800000};
        for (int i = 0; i < 2; i++) begin
            run_one(2, xs[i], y, lat);
            checks++;
            if (y[31:0] !== es[i] || lat !== 3) begin
                failures++;
                $display("FAIL in64[%0d] got=%h lat=%0d exp=%h lat=3", i, y[31:0], lat, es[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expq [$];
        logic [31:0] held;
        logic [31:0] e;
        bit hv;
        bit acc;
        bit emit;
        int sent;
        int got;
        int cyc;
        hv = 1'b0;
        sent = 0;
        got = 0;
        cyc = 0;
        held = '0;
        while (got < 10 && cyc < 60) begin
            @(negedge clk);
            rr0 = !(cyc >= 2 && cyc <= 8);
            av0 = (sent < 10);
            ad0 = 32'(sent + 1);
            #1;
            acc  = av0 && ar0;
            emit = rv0 && rr0;
            if (hv) begin
                checks++;
                if (rd0 !== held) begin
                    failures++;
                    $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, rd0, held);
                end
            end
            hv   = rv0 && !rr0;
            held = rd0;
            if (sent - got == 3 && !rr0) begin
                checks++;
                if (ar0 !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_a_ready cyc=%0d got=%b exp=0", cyc, ar0);
                end
            end
            if (cyc >= 9 && sent - got > 0) begin
                checks++;
                if (!emit) begin
                    failures++;
                    $display("FAIL bp_full_rate cyc=%0d got=0 exp=1", cyc);
                end
            end
            if (emit) begin
                e = expq.pop_front();
                checks++;
                if (rd0 !== e) begin
                    failures++;
                    $display("FAIL bp_data[%0d] got=%h exp=%h", got, rd0, e);
                end
                got++;
            end
            if (acc) begin
                expq.push_back(ref_cvt({32'd0, ad0}, 32)[31:0]);
                sent++;
            end
            @(posedge clk);
            cyc++;
        end
        #1;
        av0 = 1'b0;
        rr0 = 1'b1;
        checks++;
        if (got != 10) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=10", got);
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] expq [$];
        logic [31:0] held;
        logic [31:0] e;
        bit hv;
        bit acc;
        bit emit;
        int sent;
        int got;
        int cyc;
        hv = 1'b0;
        sent = 0;
        got = 0;
        cyc = 0;
        held = '0;
        while (got < 150 && cyc < 3000) begin
            @(negedge clk);
            rr0 = ($urandom_range(0, 9) < 6);
            av0 = (sent < 150) && ($urandom_range(0, 9) < 7);
            ad0 = $urandom >> $urandom_range(0, 31);
            #1;
            acc  = av0 && ar0;
            emit = rv0 && rr0;
            if (hv) begin
                checks++;
                if (rd0 !== held || rv0 !== 1'b1) begin
                    failures++;
                    $display("FAIL rnd_stable cyc=%0d got=%h exp=%h", cyc, rd0, held);
                end
            end
            hv   = rv0 && !rr0;
            held = rd0;
            if (emit) begin
                e = expq.pop_front();
                checks++;
                if (rd0 !== e) begin
                    failures++;
                    $display("FAIL rnd_data[%0d] got=%h exp=%h", got, rd0, e);
                end
                got++;
            end
            if (acc) begin
                expq.push_back(ref_cvt({32'd0, ad0}, 32)[31:0]);
                sent++;
            end
            @(posedge clk);
            cyc++;
        end
        #1;
        av0 = 1'b0;
        rr0 = 1'b1;
        checks++;
        if (got != 150) begin
            failures++;
            $display("FAIL rnd_count got=%0d exp=150", got);
        end
    endtask

    task automatic test_random_formats();
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] e;
        int lat;
        for (int i = 0; i < 30; i++) begin
            x = {32'd0, $urandom >> $urandom_range(0, 31)};
            e = ref_cvt(x, 64);
            run_one(1, x, y, lat);
            checks++;
            if (y !== e) begin
                failures++;
                $display("FAIL rnd_out64 in=%h got=%h exp=%h", x, y, e);
            end
            x = {$urandom, $urandom} >> $urandom_range(0, 63);
            e = ref_cvt(x, 32);
            run_one(2, x, y, lat);
            checks++;
            if (y !== e) begin
                failures++;
                $display("FAIL rnd_in64 in=%h got=%h exp=%h", x, y, e);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] y;
        int lat;
        bit stale;
        stale = 1'b0;
        rr0 = 1'b0;
        @(negedge clk);
        av0 = 1'b1;
        ad0 = 32'd5;
        @(negedge clk);
        ad0 = 32'd6;
        @(negedge clk);
        av0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rv0 !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_valid got=%b exp=1", rv0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rv0 !== 1'b0 || ar0 !== 1'b0 || rd0 !== 32'd0) begin
            failures++;
            $display("FAIL async_rst got=v%b r%b d%h exp=v0 r0 d0", rv0, ar0, rd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rr0 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rv0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("FAIL stale_after_rst got=1 exp=0");
        end
        run_one(0, 64'd2, y, lat);
        checks++;
        if (y[31:0] !== 32'h40000000 || lat !== 3) begin
            failures++;
            $display("FAIL post_rst got=%h lat=%0d exp=40000000 lat=3", y[31:0], lat);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        av0 = 1'b0; ad0 = '0; rr0 = 1'b1;
        av1 = 1'b0; ad1 = '0; rr1 = 1'b1;
        av2 = 1'b0; ad2 = '0; rr2 = 1'b1;
        test_reset();
        test_directed_32();
        test_out64();
        test_in64();
        test_backpressure();
        test_random_stream();
        test_random_formats();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
